// File: rtl/ysyx_24100012_partial_load.sv
// Partial-word load unit: issues one word read per load, extracts/extends LB/LH/LW/LBU/LHU.
// Latency: accept N, mem_req N+1, rsp_valid one cycle after rvalid; illegal requests respond at N+1.
module ysyx_24100012_partial_load #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_len,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                  state, next_state;
    logic [2:0]              func3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    err_q;
    logic                    illegal;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [DATA_WIDTH-1:0]   loaded;

    always_comb begin
        illegal = 1'b0;
        case (func3)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = addr[0];
            3'b010:         illegal = |addr[1:0];
            default:        illegal = 1'b1;
        endcase
    end

    always_comb begin
        byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (func3_q)
            3'b000:  loaded = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            3'b100:  loaded = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            3'b001:  loaded = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            3'b101:  loaded = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: loaded = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (ld_valid) next_state = illegal ? S_RESP : S_REQ;
            S_REQ:  if (mem_gnt) next_state = S_WAIT;
            S_WAIT: if (mem_rvalid || cnt == TMO_LAST) next_state = S_RESP;
            S_RESP: if (rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // rvalid takes priority over the final timeout cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            func3_q <= 3'b000;
            addr_q  <= '0;
            cnt     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (ld_valid) begin
                    func3_q <= func3;
                    addr_q  <= addr;
                    data_q  <= '0;
                    err_q   <= illegal;
                end
                S_REQ: if (mem_gnt) cnt <= '0;
                S_WAIT: if (mem_rvalid) begin
                    data_q <= loaded;
                    err_q  <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (cnt == TMO_LAST) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_ready  = !rst && (state == S_IDLE);
        mem_req   = !rst && (state == S_REQ);
        rsp_valid = !rst && (state == S_RESP);
        mem_addr  = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_len   = '0;
        if (mem_req) begin
            case (func3_q[1:0])
                2'b00:   mem_len = DATA_WIDTH'(1);
                2'b01:   mem_len = DATA_WIDTH'(2);
                default: mem_len = DATA_WIDTH'(4);
            endcase
        end
        rsp_data = rsp_valid ? data_q : '0;
        rsp_err  = rsp_valid && err_q;
    end

endmodule

// File: tb/tb_ysyx_24100012_partial_load.sv
// Directed bench for the partial load unit, built with TIMEOUT=4.
module tb_ysyx_24100012_partial_load;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_len;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_24100012_partial_load #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .func3(func3), .addr(addr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp_addr, input logic [31:0] exp_len,
                            input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                            input int rdy_wait, input logic [31:0] exp_data);
        ld_valid = 1'b1;
        func3    = f3;
        addr     = a;
        chk({name, "/ld_ready_idle"}, 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        addr     = 32'h0;
        chk({name, "/ld_ready_busy"}, 32'(ld_ready), 32'd0);
        for (int i = 0; i < gnt_wait; i++) begin
            chk({name, "/req_hold"}, 32'(mem_req), 32'd1);
            chk({name, "/addr_hold"}, mem_addr, exp_addr);
            chk({name, "/len_hold"}, mem_len, exp_len);
            tick();
        end
        mem_gnt = 1'b1;
        chk({name, "/req"}, 32'(mem_req), 32'd1);
        chk({name, "/mem_addr"}, mem_addr, exp_addr);
        chk({name, "/mem_len"}, mem_len, exp_len);
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < rv_wait; i++) begin
            chk({name, "/wait_novalid"}, 32'(rsp_valid), 32'd0);
            chk({name, "/wait_noreq"}, 32'(mem_req), 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = ~rdata;
        chk({name, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "/rsp_err"}, 32'(rsp_err), 32'd0);
        for (int i = 0; i < rdy_wait; i++) begin
            chk({name, "/data_hold"}, rsp_data, exp_data);
            chk({name, "/ld_ready_resp"}, 32'(ld_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        chk({name, "/rsp_data"}, rsp_data, exp_data);
        chk({name, "/ld_ready_hs"}, 32'(ld_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        chk({name, "/idle_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, "/idle_ready"}, 32'(ld_ready), 32'd1);
    endtask

    task automatic run_err(input string name, input logic [2:0] f3, input logic [31:0] a);
        ld_valid = 1'b1;
        func3    = f3;
        addr     = a;
        tick();
        chk({name, "/no_req"}, 32'(mem_req), 32'd0);
        chk({name, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "/rsp_err"}, 32'(rsp_err), 32'd1);
        chk({name, "/rsp_data"}, rsp_data, 32'h0);
        // keep a legal request pending through the response handshake
        func3     = 3'b010;
        addr      = 32'h8000_0000;
        rsp_ready = 1'b1;
        chk({name, "/ld_ready_hs"}, 32'(ld_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        ld_valid  = 1'b0;
        chk({name, "/no_accept_hs"}, 32'(mem_req), 32'd0);
        chk({name, "/idle_ready"}, 32'(ld_ready), 32'd1);
        chk({name, "/idle_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        ld_valid   = 1'b0;
        func3      = 3'b000;
        addr       = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        chk("rst/ld_ready", 32'(ld_ready), 32'd0);
        chk("rst/mem_req", 32'(mem_req), 32'd0);
        chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst/rsp_data", rsp_data, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst/ld_ready", 32'(ld_ready), 32'd1);

        run_load("lb_neg",  3'b000, 32'h8000_0003, 32'h8000_0000, 32'd1, 0, 0, 32'h8011_2233, 0, 32'hFFFF_FF80);
        run_load("lb_pos",  3'b000, 32'h8000_0002, 32'h8000_0000, 32'd1, 0, 0, 32'h8011_2233, 0, 32'h0000_0011);
        run_load("lbu",     3'b100, 32'h8000_0001, 32'h8000_0000, 32'd1, 1, 0, 32'h80F1_A233, 1, 32'h0000_00A2);
        run_load("lhu",     3'b101, 32'h8000_0002, 32'h8000_0000, 32'd2, 0, 0, 32'hBEEF_1234, 0, 32'h0000_BEEF);
        // rvalid lands in the fourth WAIT cycle, racing the timeout
        run_load("lh_race", 3'b001, 32'h8000_0002, 32'h8000_0000, 32'd2, 0, 3, 32'hBEEF_1234, 0, 32'hFFFF_BEEF);
        run_load("lh_low",  3'b001, 32'h8000_0004, 32'h8000_0004, 32'd2, 0, 0, 32'hBEEF_7234, 0, 32'h0000_7234);
        run_load("lw_slow", 3'b010, 32'h8000_000C, 32'h8000_000C, 32'd4, 3, 1, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF);

        run_err("lw_mis", 3'b010, 32'h8000_0006);
        run_err("lh_mis", 3'b001, 32'h8000_0001);
        run_err("f3_011", 3'b011, 32'h8000_0000);
        run_err("f3_111", 3'b111, 32'h8000_0000);

        // timeout: no rvalid ever
        ld_valid = 1'b1;
        func3    = 3'b010;
        addr     = 32'h8000_0010;
        tick();
        ld_valid = 1'b0;
        mem_gnt  = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo/wait_novalid", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("tmo/rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo/rsp_err", 32'(rsp_err), 32'd1);
        chk("tmo/rsp_data", rsp_data, 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("tmo/idle_ready", 32'(ld_ready), 32'd1);

        // reset during WAIT, then a stale rvalid
        ld_valid = 1'b1;
        func3    = 3'b010;
        addr     = 32'h8000_0020;
        tick();
        ld_valid = 1'b0;
        mem_gnt  = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rstwait/ld_ready", 32'(ld_ready), 32'd0);
        chk("rstwait/rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstwait/ready_after", 32'(ld_ready), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("rstwait/stale_valid", 32'(rsp_valid), 32'd0);
        chk("rstwait/stale_req", 32'(mem_req), 32'd0);
        chk("rstwait/stale_ready", 32'(ld_ready), 32'd1);
        tick();
        chk("rstwait/still_idle", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24100012_partial_load.md
YSYX_24100012_PARTIAL_LOAD -- requirements
Module: ysyx_24100012_partial_load

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles spent waiting for read data.
REQ-004 The block SHALL have one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ld_valid  in  1  core presents load request
- ld_ready  out  1  block accepts request
- func3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr  in  ADDR_WIDTH  byte address
- mem_req  out  1  memory read request
- mem_gnt  in  1  memory accepts request
- mem_addr  out  ADDR_WIDTH  word-aligned read address
- mem_len  out  DATA_WIDTH  access length in bytes (1/2/4)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read word
- rsp_valid  out  1  result available
- rsp_ready  in  1  core consumes result
- rsp_data  out  DATA_WIDTH  extended load result
- rsp_err  out  1  misaligned, illegal func3, or timeout

Function
REQ-006 The block SHALL implement the four-state FSM IDLE, REQ, WAIT, RESP.
REQ-007 In IDLE, ld_ready SHALL be 1; in all other states, ld_ready SHALL be 0.
REQ-008 On accept (ld_valid&&ld_ready), the block SHALL register func3 and addr.
REQ-009 On accept, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0 when the request is illegal, i.e. any of:
- func3 in {011,110,111}
- LH/LHU with addr[0]=1
- LW with addr[1:0]!=0
REQ-010 An illegal request SHALL NOT assert mem_req.
REQ-011 On accept of a legal request, the FSM SHALL go to REQ.
REQ-012 In REQ, the outputs SHALL be:
- mem_req=1
- mem_addr={addr[ADDR_WIDTH-1:2],2'b00}
- mem_len=1 for func3[1:0]=00, 2 for 01, 4 for 10
REQ-013 The mem_req, mem_addr and mem_len outputs SHALL be held stable until mem_gnt.
REQ-014 On mem_gnt in REQ, the FSM SHALL go to WAIT and clear the wait counter.
REQ-015 The mem_req output SHALL be 0 in all states other than REQ.
REQ-016 In WAIT, the wait counter SHALL increment each cycle without mem_rvalid.
REQ-017 On mem_rvalid in WAIT, the block SHALL register the extracted result into rsp_data with rsp_err=0 and go to RESP.
REQ-018 When the counter reaches TIMEOUT without mem_rvalid, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-019 A mem_rvalid arriving in the same cycle the counter hits TIMEOUT SHALL win, giving a normal response.
REQ-020 The block SHALL ignore mem_rvalid in IDLE, REQ and RESP.
REQ-021 Byte extraction SHALL be b=mem_rdata[8*addr[1:0]+:8]; LB SHALL sign-extend b and LBU SHALL zero-extend it.
REQ-022 Halfword extraction SHALL be h=mem_rdata[16*addr[1]+:16]; LH SHALL sign-extend h and LHU SHALL zero-extend it.
REQ-023 LW SHALL pass mem_rdata through unchanged.
REQ-024 In RESP, rsp_valid SHALL be 1, with rsp_data and rsp_err held stable until rsp_ready.
REQ-025 On rsp_ready in RESP, the FSM SHALL return to IDLE.
REQ-026 The block SHALL NOT accept a new request in the same cycle as the rsp_ready handshake.
REQ-027 Minimum legal latency SHALL be: accept in cycle N, mem_req in N+1, with gnt at N+1 and rvalid at N+2 giving rsp_valid at N+3.
REQ-028 With err=1, rsp_valid SHALL be asserted in the cycle after accept.

Reset
REQ-029 While rst=1, the block SHALL hold the FSM in IDLE, the counter at 0, and all outputs at 0, including ld_ready.
REQ-030 In the first cycle after rst deasserts, ld_ready SHALL be 1.
REQ-031 A reset in REQ, WAIT or RESP SHALL abandon the load, and any later mem_rvalid from the abandoned access SHALL be ignored.

Verification
REQ-032 The bench SHALL apply LB at addr 0x80000003 with mem_rdata=0x80112233 and expect rsp_data=0xFFFFFF80, err=0, and mem_addr=0x80000000, mem_len=1.
REQ-033 The bench SHALL apply LHU at addr 0x80000002 with mem_rdata=0xBEEF1234 and expect rsp_data=0x0000BEEF; the same access as LH SHALL give rsp_data=0xFFFFBEEF.
REQ-034 The bench SHALL apply LW at addr 0x80000006 and expect no mem_req, rsp_valid the next cycle, rsp_err=1, and rsp_data=0.
REQ-035 The bench SHALL apply LW with mem_gnt held low 3 cycles, mem_rvalid 2 cycles after gnt, and rsp_ready low 4 cycles, and expect mem_addr and mem_len stable through REQ, rsp_data stable through RESP, and ld_ready=0 until the cycle after rsp_ready.
REQ-036 The bench SHALL run with TIMEOUT=4 and mem_rvalid never asserted, and expect rsp_err=1 after 4 WAIT cycles.
REQ-037 The bench SHALL apply rst in WAIT followed by a late mem_rvalid, and expect no rsp_valid and ld_ready=1 after reset.
